// File: rtl/stream_fifo_pkg.sv
// Width helpers shared by the stream FIFO and its pointer controller.
package stream_fifo_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_width(input int depth);
    return idx_width(depth);
  endfunction

  // One extra bit so the fill count can represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return idx_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Wrapping read/write pointers and fill counter for a FIFO of arbitrary DEPTH.
module fifo_ptr_ctrl
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int ADDR_W = addr_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0]  usage_q,
  output logic [CNT_W-1:0]  usage_n
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // Explicit compare against the last slot keeps wrap correct for non-power-of-two depths.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    usage_n = usage_q;
    if (flush) begin
      usage_n = '0;
    end else if (push && !pop) begin
      usage_n = usage_q + 1'b1;
    end else if (pop && !push) begin
      usage_n = usage_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      usage_q <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      usage_q <= usage_n;
    end
  end

endmodule

// File: rtl/stream_fifo_wm.sv
// Ready/valid FIFO with fill count, almost-full/empty flags and a clearable
// high-watermark; DEPTH of 0 degenerates to a combinational wire.
module stream_fifo_wm
  import stream_fifo_pkg::*;
#(
  parameter bit  FALL_THROUGH = 1'b0,
  parameter int  DATA_WIDTH   = 32,
  parameter int  DEPTH        = 8,
  parameter int  AF_THRESH    = DEPTH - 1,
  parameter int  AE_THRESH    = 1,
  parameter type dtype        = logic [DATA_WIDTH-1:0],
  localparam int ADDR_W = addr_width(DEPTH),
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  dtype             data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output dtype             data_o,
  output logic [CNT_W-1:0] usage_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CNT_W-1:0] watermark_o,
  input  logic             watermark_clr_i
);

  if (DEPTH == 0) begin : g_passthru
    assign ready_o        = ready_i;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
    assign usage_o        = '0;
    assign watermark_o    = '0;
    assign almost_full_o  = 1'b0;
    assign almost_empty_o = 1'b1;
  end else begin : g_fifo
    if (AF_THRESH > DEPTH) begin : g_af_chk
      $error("stream_fifo_wm: AF_THRESH must not exceed DEPTH");
    end
    if (AE_THRESH > DEPTH) begin : g_ae_chk
      $error("stream_fifo_wm: AE_THRESH must not exceed DEPTH");
    end

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  usage_q, usage_n, wm_q;
    logic              not_empty, push, pop, push_st, pop_st;
    dtype              mem [DEPTH];

    assign not_empty = (usage_q != '0);
    assign ready_o   = (usage_q != CNT_W'(DEPTH)) && !flush_i;
    assign valid_o   = (not_empty || (FALL_THROUGH && valid_i)) && !flush_i;
    assign push      = valid_i && ready_o;
    assign pop       = valid_o && ready_i;

    // An empty fall-through FIFO hands the word straight across; storage,
    // pointers and count stay untouched for that bypassed beat.
    assign pop_st  = pop && not_empty;
    assign push_st = push && !(pop && !not_empty);
    assign data_o  = (FALL_THROUGH && !not_empty) ? data_i : mem[rd_ptr];

    fifo_ptr_ctrl #(
      .DEPTH (DEPTH)
    ) u_ptr_ctrl (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush   (flush_i),
      .push    (push_st),
      .pop     (pop_st),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr),
      .usage_q (usage_q),
      .usage_n (usage_n)
    );

    always_ff @(posedge clk_i) begin
      if (push_st) mem[wr_ptr] <= data_i;
    end

    // Tracks the next-cycle count so the peak is visible the cycle it is reached.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wm_q <= '0;
      end else if (watermark_clr_i) begin
        wm_q <= usage_n;
      end else if (usage_n > wm_q) begin
        wm_q <= usage_n;
      end
    end

    assign usage_o        = usage_q;
    assign watermark_o    = wm_q;
    assign almost_full_o  = (int'(usage_q) >= AF_THRESH);
    assign almost_empty_o = (int'(usage_q) <= AE_THRESH);
  end

  a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o) |=> valid_i);

  a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i) |=> $stable(data_o));

endmodule
